// File: rtl/game_pkg.sv
// Shared definitions for the game input path: direction indices, the
// direction vector type, the movement FSM states and opposing-press resolution.
package game_pkg;

  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;

  typedef logic [3:0] dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } move_state_t;

  // Up+down together cancel, left+right together cancel; diagonals pass.
  function automatic dir_t resolve_opposing(input dir_t d);
    dir_t r;
    r = d;
    if (d[UP] && d[DOWN]) begin
      r[UP]   = 1'b0;
      r[DOWN] = 1'b0;
    end
    if (d[LEFT] && d[RIGHT]) begin
      r[LEFT]  = 1'b0;
      r[RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-FF synchronizer followed by a stability counter. The
// debounced level only follows the synchronized level after it has differed
// for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreement; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Movement input conditioning: four debounced buttons, opposing-press
// resolution and a strobe FSM feeding the player movement block.
// Build option MOVE_REPEAT_EN: when defined, a held direction re-strobes every
// REPEAT_CYCLES cycles; when undefined, each press strobes once and the
// repeat timer is not built.
//
//   state | meaning
//   IDLE  | no effective direction held (or title screen active)
//   HOLD  | direction held; strobes on new bits (and on timer expiry with repeat)
module move_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 1666666
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_up,
  input  logic raw_down,
  input  logic raw_left,
  input  logic raw_right,
  input  logic titleScreen,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic held
);

  dir_t raw_v;
  dir_t deb;
  dir_t eff_q;

  move_state_t state_q, state_d;
  dir_t        strobe_q, strobe_d;
  dir_t        last_q, last_d;
  logic        held_q, held_d;

`ifdef MOVE_REPEAT_EN
  localparam int TW = $clog2(REPEAT_CYCLES);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(REPEAT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

  assign raw_v[UP]    = raw_up;
  assign raw_v[DOWN]  = raw_down;
  assign raw_v[LEFT]  = raw_left;
  assign raw_v[RIGHT] = raw_right;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw_i(raw_v[i]),
      .deb_o(deb[i])
    );
  end

  // Registered resolution: this stage absorbs the raw-edge alignment cycle
  // and keeps the cancel logic off the FSM decision path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) eff_q <= '0;
    else        eff_q <= resolve_opposing(deb);
  end

  // Next-state and strobe decision; release has priority over expiry, and a
  // new bit coinciding with expiry yields a single strobe.
  always_comb begin
    state_d  = state_q;
    strobe_d = '0;
    last_d   = last_q;
`ifdef MOVE_REPEAT_EN
    timer_d  = timer_q;
`endif
    if (titleScreen) begin
      state_d = IDLE;
`ifdef MOVE_REPEAT_EN
      timer_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (eff_q != '0) begin
            strobe_d = eff_q;
            last_d   = eff_q;
            state_d  = HOLD;
`ifdef MOVE_REPEAT_EN
            timer_d  = TIMER_RELOAD;
`endif
          end
        end
        HOLD: begin
          if (eff_q == '0) begin
            state_d = IDLE;
`ifdef MOVE_REPEAT_EN
            timer_d = '0;
`endif
          end else if ((eff_q & ~last_q) != '0) begin
            strobe_d = eff_q;
            last_d   = eff_q;
`ifdef MOVE_REPEAT_EN
            timer_d  = TIMER_RELOAD;
          end else if (timer_q == '0) begin
            strobe_d = eff_q;
            last_d   = eff_q;
            timer_d  = TIMER_RELOAD;
          end else begin
            timer_d  = timer_q - TW'(1);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
    held_d = (state_d == HOLD);
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      strobe_q <= '0;
      last_q   <= '0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
      held_q   <= held_d;
    end
  end

`ifdef MOVE_REPEAT_EN
  // Repeat timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`endif

  assign up    = strobe_q[UP];
  assign down  = strobe_q[DOWN];
  assign left  = strobe_q[LEFT];
  assign right = strobe_q[RIGHT];
  assign held  = held_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
module tb_move_input_ctrl;

  localparam int D = 4;
  localparam int R = 10;
`ifdef MOVE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_up = 1'b0, raw_down = 1'b0, raw_left = 1'b0, raw_right = 1'b0;
  logic titleScreen = 1'b0;
  logic up, down, left, right, held;

  int tests = 0;
  int fails = 0;

  move_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_up     (raw_up),
    .raw_down   (raw_down),
    .raw_left   (raw_left),
    .raw_right  (raw_right),
    .titleScreen(titleScreen),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .held       (held)
  );

  always #5 clk = ~clk;

  // Behavioural reference: delay line for sync, run-length debounce,
  // and an absolute-cycle deadline for repeats.
  logic [3:0] m_s1, m_s2, m_deb, m_eff, m_strobe, m_last;
  int         m_run[4];
  bit         m_hold;
  longint     m_due;
  longint     cyc = 0;

  function automatic logic [3:0] resolve(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[0] && d[1]) r[1:0] = 2'b00;
    if (d[2] && d[3]) r[3:2] = 2'b00;
    return r;
  endfunction

  function automatic logic [4:0] dut_out();
    return {held, right, left, down, up};
  endfunction

  function automatic logic [4:0] mdl_out();
    return {m_hold, m_strobe};
  endfunction

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_eff = '0;
    m_strobe = '0; m_last = '0; m_hold = 1'b0; m_due = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_tick();
    logic [3:0] raw_now;
    logic [3:0] deb_n;
    logic [3:0] strobe_n;
    raw_now  = {raw_right, raw_left, raw_down, raw_up};
    deb_n    = m_deb;
    strobe_n = '0;
    cyc++;
    if (!reset) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          deb_n[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (titleScreen) begin
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (m_eff != 0) begin
        strobe_n = m_eff; m_last = m_eff; m_hold = 1'b1; m_due = cyc + R;
      end
    end else if (m_eff == 0) begin
      m_hold = 1'b0;
    end else if ((m_eff & ~m_last) != 0 || (REP && cyc == m_due)) begin
      strobe_n = m_eff; m_last = m_eff; m_due = cyc + R;
    end
    m_strobe = strobe_n;
    m_eff    = resolve(m_deb);
    m_deb    = deb_n;
    m_s2     = m_s1;
    m_s1     = raw_now;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_raw(input logic [3:0] v);
    {raw_right, raw_left, raw_down, raw_up} = v;
  endtask

  task automatic settle();
    set_raw(4'b0000);
    titleScreen = 1'b0;
    repeat (3 * D + R + 12) tick();
  endtask

  task automatic test_reset();
    model_clear();
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (dut_out() !== 5'b00000) begin
        fails++;
        $display("FAIL reset_state k=%0d got=%b exp=00000", k, dut_out());
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_single_press();
    int t[$]; logic [3:0] v[$]; int rise = -1; int fall = -1;
    int exp_t[$];
    exp_t = {D + 4};
    if (REP) exp_t = {D + 4, D + 4 + R, D + 4 + 2 * R};
    set_raw(4'b0001);
    for (int k = 1; k <= 45; k++) begin
      tick();
      tests++;
      if (dut_out() !== mdl_out()) begin
        fails++;
        $display("FAIL single_press_model k=%0d got=%b exp=%b", k, dut_out(), mdl_out());
      end
      if ({right, left, down, up} != 4'b0000) begin t.push_back(k); v.push_back({right, left, down, up}); end
      if (held && rise < 0) rise = k;
      if (!held && rise >= 0 && fall < 0) fall = k;
      if (k == 30) set_raw(4'b0000);
    end
    tests++;
    if (t.size() != exp_t.size()) begin
      fails++;
      $display("FAIL single_press_count got=%0d exp=%0d", t.size(), exp_t.size());
    end else begin
      foreach (exp_t[i]) begin
        tests++;
        if (t[i] != exp_t[i] || v[i] !== 4'b0001) begin
          fails++;
          $display("FAIL single_press_strobe%0d got=%0d/%b exp=%0d/0001", i, t[i], v[i], exp_t[i]);
        end
      end
    end
    tests++;
    if (rise != D + 4 || fall != 30 + D + 4) begin
      fails++;
      $display("FAIL single_press_held got=%0d..%0d exp=%0d..%0d", rise, fall, D + 4, 30 + D + 4);
    end
    settle();
  endtask

  task automatic test_bounce();
    int n = 0;
    set_raw(4'b0100);
    for (int k = 1; k <= 40; k++) begin
      tick();
      tests++;
      if (dut_out() !== mdl_out()) begin
        fails++;
        $display("FAIL bounce_model k=%0d got=%b exp=%b", k, dut_out(), mdl_out());
      end
      if (dut_out() != 5'b00000) n++;
      if (k < 20 && (k % 2) == 0) raw_left = ~raw_left;
      if (k == 20) set_raw(4'b0000);
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL bounce_quiet got=%0d active cycles exp=0", n);
    end
    settle();
  endtask

  task automatic test_opposing_diag();
    int t[$]; logic [3:0] v[$]; int exp_t[$]; logic [3:0] exp_v[$];
    exp_t = {28, 38};
    exp_v = {4'b0001, 4'b1001};
    if (REP) begin
      exp_t = {28, 38, 48, 58};
      exp_v = {4'b0001, 4'b1001, 4'b1001, 4'b1001};
    end
    set_raw(4'b0011);
    for (int k = 1; k <= 75; k++) begin
      tick();
      tests++;
      if (dut_out() !== mdl_out()) begin
        fails++;
        $display("FAIL opposing_model k=%0d got=%b exp=%b", k, dut_out(), mdl_out());
      end
      if ({right, left, down, up} != 4'b0000) begin t.push_back(k); v.push_back({right, left, down, up}); end
      if (k == 20) set_raw(4'b0001);
      if (k == 30) set_raw(4'b1001);
      if (k == 55) set_raw(4'b0000);
    end
    tests++;
    if (t.size() != exp_t.size()) begin
      fails++;
      $display("FAIL opposing_count got=%0d exp=%0d", t.size(), exp_t.size());
    end else begin
      foreach (exp_t[i]) begin
        tests++;
        if (t[i] != exp_t[i] || v[i] !== exp_v[i]) begin
          fails++;
          $display("FAIL opposing_strobe%0d got=%0d/%b exp=%0d/%b", i, t[i], v[i], exp_t[i], exp_v[i]);
        end
      end
    end
    settle();
  endtask

  task automatic test_title();
    int first = -1; logic [3:0] fv = '0; int held_seen = 0;
    titleScreen = 1'b1;
    set_raw(4'b1000);
    for (int k = 1; k <= 50; k++) begin
      tick();
      tests++;
      if (dut_out() !== mdl_out()) begin
        fails++;
        $display("FAIL title_model k=%0d got=%b exp=%b", k, dut_out(), mdl_out());
      end
      if (k <= 40 && held) held_seen++;
      if ({right, left, down, up} != 4'b0000 && first < 0) begin first = k; fv = {right, left, down, up}; end
      if (k == 40) titleScreen = 1'b0;
    end
    tests++;
    if (first != 41 || fv !== 4'b1000 || held_seen != 0) begin
      fails++;
      $display("FAIL title_release got=%0d/%b held=%0d exp=41/1000 held=0", first, fv, held_seen);
    end
    settle();
  endtask

  task automatic test_reset_mid_hold();
    int first = -1;
    set_raw(4'b0001);
    repeat (12) tick();
    tests++;
    if (held !== 1'b1) begin
      fails++;
      $display("FAIL midhold_held got=%b exp=1", held);
    end
    reset = 1'b0;
    model_clear();
    #1;
    tests++;
    if (dut_out() !== 5'b00000) begin
      fails++;
      $display("FAIL midhold_async got=%b exp=00000", dut_out());
    end
    repeat (3) tick();
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      tests++;
      if (dut_out() !== mdl_out()) begin
        fails++;
        $display("FAIL midhold_model k=%0d got=%b exp=%b", k, dut_out(), mdl_out());
      end
      if (up && first < 0) first = k;
    end
    tests++;
    if (first != D + 4) begin
      fails++;
      $display("FAIL midhold_restrobe got=%0d exp=%0d", first, D + 4);
    end
    settle();
  endtask

  task automatic test_hold_long();
    int t[$]; int exp_t[$];
    exp_t = {8};
    if (REP) exp_t = {8, 18, 28, 38, 48};
    set_raw(4'b0010);
    for (int k = 1; k <= 70; k++) begin
      tick();
      tests++;
      if (dut_out() !== mdl_out()) begin
        fails++;
        $display("FAIL hold_long_model k=%0d got=%b exp=%b", k, dut_out(), mdl_out());
      end
      if ({right, left, down, up} == 4'b0010) t.push_back(k);
      else if ({right, left, down, up} != 4'b0000) t.push_back(-k);
      if (k == 50) set_raw(4'b0000);
    end
    tests++;
    if (t != exp_t) begin
      fails++;
      $display("FAIL hold_long_strobes got=%p exp=%p", t, exp_t);
    end
    settle();
  endtask

  task automatic test_random();
    int left_cycles = 0;
    for (int k = 0; k < 2000; k++) begin
      if (left_cycles == 0) begin
        set_raw(4'($urandom_range(0, 15)));
        left_cycles = $urandom_range(1, 3 * D + R);
        if ($urandom_range(0, 9) == 0) titleScreen = ~titleScreen;
        if ($urandom_range(0, 39) == 0) begin
          reset = 1'b0;
          model_clear();
        end else begin
          reset = 1'b1;
        end
      end
      left_cycles--;
      tick();
      tests++;
      if (dut_out() !== mdl_out()) begin
        fails++;
        $display("FAIL random k=%0d got=%b exp=%b", k, dut_out(), mdl_out());
      end
    end
    reset = 1'b1;
    settle();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_opposing_diag();
    test_title();
    test_reset_mid_hold();
    test_hold_long();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
